// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered
// carry between chunks, valid/ready handshakes on request and result.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK:0]   part;
  logic             msb_cin;

  // Operands shift right one chunk per cycle; the result fills from the top.
  always_comb begin
    part = {1'b0, a_q[CHUNK-1:0]}
         + {1'b0, b_q[CHUNK-1:0]}
         + {{CHUNK{1'b0}}, carry_q};
    msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ part[CHUNK-1];

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : carry_i;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = (sum_q >> CHUNK)
                | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = part[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          ovf_d   = msb_cin ^ part[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign res_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed 32/8 vectors, handshake corners,
// and a 16-bit sweep across CHUNK=16/4/1 against a reference model.
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [31:0] a_i, b_i, sum_o;
  logic        carry_i, sub_i;
  logic        res_valid_o, res_ready_i;
  logic        carry_o, overflow_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .sum_o(sum_o), .carry_o(carry_o), .overflow_o(overflow_o)
  );

  logic        v16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        rq16 [3];
  logic        rv16 [3];
  logic [15:0] s16  [3];
  logic        c16  [3];
  logic        o16  [3];

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u16_c16 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v16), .req_ready_o(rq16[0]),
    .a_i(a16), .b_i(b16), .carry_i(cin16), .sub_i(sub16),
    .res_valid_o(rv16[0]), .res_ready_i(1'b1),
    .sum_o(s16[0]), .carry_o(c16[0]), .overflow_o(o16[0])
  );
  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u16_c4 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v16), .req_ready_o(rq16[1]),
    .a_i(a16), .b_i(b16), .carry_i(cin16), .sub_i(sub16),
    .res_valid_o(rv16[1]), .res_ready_i(1'b1),
    .sum_o(s16[1]), .carry_o(c16[1]), .overflow_o(o16[1])
  );
  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u16_c1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v16), .req_ready_o(rq16[2]),
    .a_i(a16), .b_i(b16), .carry_i(cin16), .sub_i(sub16),
    .res_valid_o(rv16[2]), .res_ready_i(1'b1),
    .sum_o(s16[2]), .carry_o(c16[2]), .overflow_o(o16[2])
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Starts and ends on a negedge; returns with res_valid_o high
  // (or after the wait bound), latency counted from the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub,
                        output int lat);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 64'(req_ready_o), 64'(1));
    req_valid_i = 1'b1;
    a_i = a;
    b_i = b;
    carry_i = cin;
    sub_i = sub;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1;
    while (!res_valid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("res_valid_wait", 64'(res_valid_o), 64'(1));
  endtask

  task automatic consume();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    int e;
    logic [2:0] done;
    logic [16:0] full;
    logic [15:0] bb, es;
    logic ec, eo;
    int nn [3];

    tv[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
              32'h0000_0100, 1'b0, 1'b0};
    tv[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
              32'h0000_0000, 1'b1, 1'b0};
    tv[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
              32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
              32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              32'h8000_0000, 1'b0, 1'b1};
    tv[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
              32'h0000_0000, 1'b1, 1'b1};
    tv[6] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1,
              32'h0000_0000, 1'b1, 1'b0};
    tv[7] = '{32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1,
              32'h0000_000F, 1'b1, 1'b0};
    tv[8] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
              32'h2345_6789, 1'b0, 1'b0};
    nn[0] = 1;
    nn[1] = 4;
    nn[2] = 16;

    rst = 1'b1;
    req_valid_i = 1'b0;
    res_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    carry_i = 1'b0;
    sub_i = 1'b0;
    v16 = 1'b0;
    a16 = '0;
    b16 = '0;
    cin16 = 1'b0;
    sub16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 64'(req_ready_o), 64'(1));
    chk("rst_res_valid", 64'(res_valid_o), 64'(0));
    chk("rst_sum", 64'(sum_o), 64'(0));
    chk("rst_carry", 64'(carry_o), 64'(0));
    chk("rst_ovf", 64'(overflow_o), 64'(0));

    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, lat);
      chk($sformatf("v%0d_sum", i), 64'(sum_o), 64'(tv[i].s));
      chk($sformatf("v%0d_carry", i), 64'(carry_o), 64'(tv[i].c));
      chk($sformatf("v%0d_ovf", i), 64'(overflow_o), 64'(tv[i].o));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(5));
      consume();
      chk($sformatf("v%0d_idle", i), 64'(req_ready_o), 64'(1));
    end

    // Back-pressure with busy inputs toggling underneath.
    run_op(32'h5, 32'h7, 1'b0, 1'b1, lat);
    for (int k = 0; k < 10; k++) begin
      a_i = $urandom;
      b_i = $urandom;
      sub_i = k[1];
      carry_i = k[0];
      req_valid_i = k[0];
      @(negedge clk);
      chk("bp_sum", 64'(sum_o), 64'(32'hFFFF_FFFE));
      chk("bp_carry", 64'(carry_o), 64'(0));
      chk("bp_ovf", 64'(overflow_o), 64'(0));
      chk("bp_valid", 64'(res_valid_o), 64'(1));
      chk("bp_ready", 64'(req_ready_o), 64'(0));
    end
    a_i = 32'h1;
    b_i = 32'h2;
    carry_i = 1'b0;
    sub_i = 1'b0;
    req_valid_i = 1'b1;
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("bp_hs_ready", 64'(req_ready_o), 64'(1));
    chk("bp_hs_valid", 64'(res_valid_o), 64'(0));
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("bp_acc_ready", 64'(req_ready_o), 64'(0));
    lat = 1;
    while (!res_valid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp2_lat", 64'(lat), 64'(5));
    chk("bp2_sum", 64'(sum_o), 64'(32'h3));
    consume();

    // Reset on the second CALC cycle.
    a_i = 32'hDEAD_BEEF;
    b_i = 32'h0123_4567;
    sub_i = 1'b0;
    carry_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", 64'(res_valid_o), 64'(0));
    chk("mrst_sum", 64'(sum_o), 64'(0));
    chk("mrst_ready", 64'(req_ready_o), 64'(1));
    chk("mrst_carry", 64'(carry_o), 64'(0));
    chk("mrst_ovf", 64'(overflow_o), 64'(0));
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    chk("mrst_sum2", 64'(sum_o), 64'(32'h2345_6789));
    chk("mrst_lat2", 64'(lat), 64'(5));
    consume();

    // 16-bit sweep, CHUNK = 16 / 4 / 1 in lockstep.
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      sub16 = 1'($urandom);
      bb = sub16 ? ~b16 : b16;
      full = {1'b0, a16} + {1'b0, bb} + 17'(sub16 ? 1'b1 : cin16);
      es = full[15:0];
      ec = full[16];
      eo = (a16[15] == bb[15]) && (es[15] != a16[15]);
      v16 = 1'b1;
      @(negedge clk);
      v16 = 1'b0;
      done = '0;
      e = 1;
      while (done != 3'b111 && e < 40) begin
        for (int j = 0; j < 3; j++) begin
          if (!done[j] && rv16[j]) begin
            done[j] = 1'b1;
            chk($sformatf("sw%0d_sum", nn[j]), 64'(s16[j]), 64'(es));
            chk($sformatf("sw%0d_carry", nn[j]), 64'(c16[j]), 64'(ec));
            chk($sformatf("sw%0d_ovf", nn[j]), 64'(o16[j]), 64'(eo));
            chk($sformatf("sw%0d_lat", nn[j]), 64'(e), 64'(nn[j] + 1));
          end
        end
        if (done != 3'b111) begin
          @(negedge clk);
          e++;
        end
      end
      chk("sw_all_done", 64'(done), 64'(3'b111));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
